// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage -- registered write-back stage of the pipelined RV32 CPU.
//
// Sits between the MEM/WB boundary and the register file. It picks the
// write-back value (ALU, load data, PC+4 link, immediate). It holds a load
// until its data-memory response arrives. It publishes forwarding and hazard
// status, and it counts retired instructions.
//
// Optional feature: define WB_LOAD_ALIGN_EN to shift and extend sub-word loads
// (LB/LH/LBU/LHU) using the captured funct3/addr_lo. Without the macro the
// response word is written unaltered.
//
// Ports
//   clk, rstn            clock (rising edge), async active-low reset
//   in_valid/in_ready    MEM-stage handshake; in_ready depends on state only
//   in_regwrite, in_rd   destination write enable / index
//   in_wdsel             00 ALU, 01 MEM, 10 PC link, 11 IMM
//   in_aluout/imm/pc     candidate write-back sources
//   in_funct3/addr_lo    load type and byte offset (used with WB_LOAD_ALIGN_EN)
//   mem_rvalid/rdata     data-memory response
//   flush                squash an uncommitted entry
//   rf_we/waddr/wdata    register-file write port (registered)
//   fwd_valid/rd/data    committing value for forwarding
//   fwd_pending          load outstanding for fwd_rd
//   retired              committed-instruction count (wraps)
// ---------------------------------------------------------------------------
module wb_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5,
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_regwrite,
    input  logic [REGW-1:0] in_rd,
    input  logic [1:0]      in_wdsel,
    input  logic [XLEN-1:0] in_aluout,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_pc,
    input  logic [2:0]      in_funct3,
    input  logic [1:0]      in_addr_lo,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            flush,
    output logic            rf_we,
    output logic [REGW-1:0] rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            fwd_valid,
    output logic [REGW-1:0] fwd_rd,
    output logic [XLEN-1:0] fwd_data,
    output logic            fwd_pending,
    output logic [CNTW-1:0] retired
);

    typedef enum logic [1:0] {IDLE, WAIT_MEM, COMMIT, DRAIN} state_e;

    state_e          state_q, state_d;
    logic            regwrite_q, regwrite_d;
    logic            rf_we_q, rf_we_d;
    logic [REGW-1:0] rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    logic            fwd_pending_q, fwd_pending_d;
    logic [CNTW-1:0] retired_q, retired_d;

    logic            accept;
    logic [XLEN-1:0] sel_data;
    logic [XLEN-1:0] load_data;

    assign in_ready = (state_q == IDLE) || (state_q == COMMIT);
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        case (in_wdsel)
            2'b10:   sel_data = in_pc + XLEN'(4);
            2'b11:   sel_data = in_imm;
            default: sel_data = in_aluout;
        endcase
    end

`ifdef WB_LOAD_ALIGN_EN
    logic [2:0]      funct3_q;
    logic [1:0]      addr_lo_q;
    logic [XLEN-1:0] shifted;
    logic            unused_shift_hi;

    always_comb begin
        shifted   = mem_rdata >> {addr_lo_q, 3'b000};
        load_data = mem_rdata;
        case (funct3_q)
            3'b000: load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            3'b100: load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            // A halfword at offset 3 straddles the word; leave it raw.
            3'b001: if (addr_lo_q != 2'b11)
                        load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            3'b101: if (addr_lo_q != 2'b11)
                        load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: load_data = mem_rdata;
        endcase
    end
    assign unused_shift_hi = ^shifted[XLEN-1:16];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            funct3_q  <= 3'b000;
            addr_lo_q <= 2'b00;
        end else if (accept) begin
            funct3_q  <= in_funct3;
            addr_lo_q <= in_addr_lo;
        end
    end
`else
    logic unused_load_fields;
    assign load_data          = mem_rdata;
    assign unused_load_fields = ^{in_funct3, in_addr_lo};
`endif

    always_comb begin
        state_d    = state_q;
        regwrite_d = regwrite_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        // COMMIT lasts exactly one cycle, so count it on the way out.
        retired_d  = retired_q + CNTW'(state_q == COMMIT);
        case (state_q)
            IDLE, COMMIT: begin
                state_d = IDLE;
                if (accept) begin
                    regwrite_d = in_regwrite;
                    rf_waddr_d = in_rd;
                    if (in_wdsel == 2'b01) begin
                        state_d = WAIT_MEM;
                    end else begin
                        state_d    = COMMIT;
                        rf_we_d    = in_regwrite && (in_rd != '0);
                        rf_wdata_d = sel_data;
                    end
                end
            end
            WAIT_MEM: begin
                // A flush racing the response drops the response with it;
                // otherwise one response is still owed and must be swallowed.
                if (flush) begin
                    state_d = mem_rvalid ? IDLE : DRAIN;
                end else if (mem_rvalid) begin
                    state_d    = COMMIT;
                    rf_we_d    = regwrite_q && (rf_waddr_q != '0);
                    rf_wdata_d = load_data;
                end
            end
            DRAIN: begin
                if (mem_rvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        fwd_pending_d = (state_d == WAIT_MEM) && regwrite_d && (rf_waddr_d != '0);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            regwrite_q    <= 1'b0;
            rf_we_q       <= 1'b0;
            rf_waddr_q    <= '0;
            rf_wdata_q    <= '0;
            fwd_pending_q <= 1'b0;
            retired_q     <= '0;
        end else begin
            state_q       <= state_d;
            regwrite_q    <= regwrite_d;
            rf_we_q       <= rf_we_d;
            rf_waddr_q    <= rf_waddr_d;
            rf_wdata_q    <= rf_wdata_d;
            fwd_pending_q <= fwd_pending_d;
            retired_q     <= retired_d;
        end
    end

    assign rf_we       = rf_we_q;
    assign rf_waddr    = rf_waddr_q;
    assign rf_wdata    = rf_wdata_q;
    assign fwd_valid   = rf_we_q;
    assign fwd_rd      = rf_waddr_q;
    assign fwd_data    = rf_wdata_q;
    assign fwd_pending = fwd_pending_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_wb_stage -- directed scenarios followed by random traffic for wb_stage.
// Outputs are compared every cycle against a transaction-level model: at most
// one outstanding load, at most one owed (discarded) response, and the
// instruction committing this cycle.
// ---------------------------------------------------------------------------
module tb_wb_stage;
    localparam int XLEN = 32;
    localparam int REGW = 5;
    localparam int CNTW = 32;
`ifdef WB_LOAD_ALIGN_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rstn = 1'b1;
    logic            in_valid = 1'b0, in_ready, in_regwrite = 1'b0;
    logic [REGW-1:0] in_rd = '0;
    logic [1:0]      in_wdsel = 2'b00;
    logic [XLEN-1:0] in_aluout = '0, in_imm = '0, in_pc = '0, mem_rdata = '0;
    logic [2:0]      in_funct3 = 3'b010;
    logic [1:0]      in_addr_lo = 2'b00;
    logic            mem_rvalid = 1'b0, flush = 1'b0;
    logic            rf_we, fwd_valid, fwd_pending;
    logic [REGW-1:0] rf_waddr, fwd_rd;
    logic [XLEN-1:0] rf_wdata, fwd_data;
    logic [CNTW-1:0] retired;

    always #5 clk = ~clk;

    wb_stage #(.XLEN(XLEN), .REGW(REGW), .CNTW(CNTW)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready), .in_regwrite(in_regwrite),
        .in_rd(in_rd), .in_wdsel(in_wdsel), .in_aluout(in_aluout),
        .in_imm(in_imm), .in_pc(in_pc), .in_funct3(in_funct3),
        .in_addr_lo(in_addr_lo), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .flush(flush), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .fwd_pending(fwd_pending), .retired(retired)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---- reference model ----
    bit          m_ld;       // a load is waiting for its response
    bit          m_owed;     // a squashed load's response has yet to arrive
    bit          m_c;        // an instruction commits this cycle
    bit          m_c_rw;
    logic [4:0]  m_c_rd;
    logic [31:0] m_c_data;
    bit          m_e_rw;
    logic [4:0]  m_e_rd;
    logic [2:0]  m_e_f3;
    logic [1:0]  m_e_lo;
    int unsigned m_ret;

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] lo);
        int unsigned sh;
        int          v;
        sh = w >> (8 * lo);
        case (f3)
            3'd0: begin v = int'(sh % 256); if (v >= 128) v -= 256; return 32'(v); end
            3'd4: return sh % 256;
            3'd1: begin
                if (lo == 2'd3) return w;
                v = int'(sh % 65536); if (v >= 32768) v -= 65536; return 32'(v);
            end
            3'd5: return (lo == 2'd3) ? w : sh % 65536;
            default: return w;
        endcase
    endfunction

    task automatic model_clear();
        m_ld = 0; m_owed = 0; m_c = 0; m_ret = 0;
    endtask

    // Advance the model across one rising edge using the inputs held there.
    task automatic model_step();
        if (m_c) m_ret++;
        m_c = 0;
        if (m_ld) begin
            if (flush) begin
                m_ld = 0; m_owed = !mem_rvalid;
            end else if (mem_rvalid) begin
                m_ld = 0; m_c = 1; m_c_rw = m_e_rw; m_c_rd = m_e_rd;
                m_c_data = ALIGN ? ref_load(mem_rdata, m_e_f3, m_e_lo) : mem_rdata;
            end
        end else if (m_owed) begin
            if (mem_rvalid) m_owed = 0;
        end else if (in_valid && !flush) begin
            if (in_wdsel == 2'b01) begin
                m_ld = 1; m_e_rw = in_regwrite; m_e_rd = in_rd;
                m_e_f3 = in_funct3; m_e_lo = in_addr_lo;
            end else begin
                m_c = 1; m_c_rw = in_regwrite; m_c_rd = in_rd;
                m_c_data = (in_wdsel == 2'b00) ? in_aluout :
                           (in_wdsel == 2'b10) ? in_pc + 32'd4 : in_imm;
            end
        end
    endtask

    task automatic check_outputs();
        bit exp_we, exp_pend;
        exp_we   = m_c && m_c_rw && (m_c_rd != 0);
        exp_pend = m_ld && m_e_rw && (m_e_rd != 0);
        chk("rf_we", rf_we, exp_we);
        chk("fwd_valid", fwd_valid, exp_we);
        chk("fwd_pending", fwd_pending, exp_pend);
        chk("in_ready", in_ready, !m_ld && !m_owed);
        chk("retired", retired, m_ret);
        if (exp_we) begin
            chk("rf_waddr", rf_waddr, m_c_rd);
            chk("rf_wdata", rf_wdata, m_c_data);
            chk("fwd_rd", fwd_rd, m_c_rd);
            chk("fwd_data", fwd_data, m_c_data);
        end else if (m_ld) begin
            chk("fwd_rd_pend", fwd_rd, m_e_rd);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_step();
        check_outputs();
    endtask

    task automatic set_idle();
        in_valid = 0; mem_rvalid = 0; flush = 0;
    endtask

    task automatic drive_op(input logic [1:0] ws, input logic rw, input logic [4:0] rd);
        in_valid = 1; in_wdsel = ws; in_regwrite = rw; in_rd = rd;
        mem_rvalid = 0; flush = 0;
    endtask

    task automatic do_reset();
        rstn = 0;
        set_idle();
        #2;
        chk("rst_rf_we", rf_we, 0);
        chk("rst_fwd_valid", fwd_valid, 0);
        chk("rst_fwd_pending", fwd_pending, 0);
        chk("rst_rf_waddr", rf_waddr, 0);
        chk("rst_fwd_rd", fwd_rd, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        chk("rst_fwd_data", fwd_data, 0);
        chk("rst_retired", retired, 0);
        chk("rst_in_ready", in_ready, 1);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rstn = 1;
    endtask

    task automatic load_resp(input logic [2:0] f3, input logic [1:0] lo,
                             input logic [31:0] word, input logic [31:0] exp);
        drive_op(2'b01, 1, 5'd3); in_funct3 = f3; in_addr_lo = lo;
        step();
        set_idle(); mem_rvalid = 1; mem_rdata = word;
        step();
        chk("align_data", rf_wdata, exp);
        set_idle();
        step();
    endtask

    logic [2:0]  f3_tab [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    int unsigned ret_mark;

    initial begin
        #1;
        do_reset();

        // back-to-back ALU / IMM / PC link
        drive_op(2'b00, 1, 5'd1); in_aluout = 32'h11;
        step(); chk("b2b_alu", rf_wdata, 32'h11);
        drive_op(2'b11, 1, 5'd2); in_imm = 32'h22000;
        step(); chk("b2b_imm", rf_wdata, 32'h22000);
        drive_op(2'b10, 1, 5'd3); in_pc = 32'h100;
        step(); chk("b2b_pc", rf_wdata, 32'h104);
        set_idle();
        step(); chk("b2b_retired", retired, 3);

        // load with a three-cycle response
        drive_op(2'b01, 1, 5'd5); in_funct3 = 3'b010; in_addr_lo = 2'b00;
        mem_rvalid = 1; mem_rdata = 32'h1234;  // same-cycle response is not the load's
        step();
        set_idle();
        step();
        step();
        chk("ld_pending", fwd_pending, 1);
        chk("ld_not_ready", in_ready, 0);
        chk("ld_fwd_rd", fwd_rd, 5);
        mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
        step();
        chk("ld_we", rf_we, 1);
        chk("ld_rd", rf_waddr, 5);
        chk("ld_data", rf_wdata, 32'hDEADBEEF);
        set_idle();
        step();

        // sub-word alignment (raw word when the feature is off)
        load_resp(3'b000, 2'd2, 32'h00800000, ALIGN ? 32'hFFFFFF80 : 32'h00800000);
        load_resp(3'b101, 2'd2, 32'hBEEF0000, ALIGN ? 32'h0000BEEF : 32'hBEEF0000);
        load_resp(3'b001, 2'd3, 32'h80FF00AA, 32'h80FF00AA);

        // flush while waiting, response two cycles later
        ret_mark = m_ret;
        drive_op(2'b01, 1, 5'd7);
        step();
        set_idle(); flush = 1;
        step();
        set_idle();
        step();
        chk("fl_still_busy", in_ready, 0);
        mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
        step();
        chk("fl_no_we", rf_we, 0);
        chk("fl_ready", in_ready, 1);
        set_idle();
        step();
        chk("fl_retired", retired, ret_mark);

        // x0 target and regwrite=0 still retire
        ret_mark = m_ret;
        drive_op(2'b00, 1, 5'd0); in_aluout = 32'h55;
        step(); chk("x0_no_we", rf_we, 0);
        drive_op(2'b00, 0, 5'd9);
        step(); chk("norw_no_we", rf_we, 0);
        set_idle();
        step(); chk("nowrite_retired", retired, ret_mark + 2);

        // PC link wraps
        drive_op(2'b10, 1, 5'd4); in_pc = 32'hFFFFFFFE;
        step(); chk("pc_wrap", rf_wdata, 32'h2);
        set_idle();
        step();

        // reset mid-load, stale response afterwards
        drive_op(2'b01, 1, 5'd6);
        step();
        do_reset();
        mem_rvalid = 1; mem_rdata = 32'h77;
        step();
        chk("stale_no_we", rf_we, 0);
        chk("stale_ready", in_ready, 1);
        set_idle();
        step();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid    = ($urandom_range(0, 9) < 7);
            in_regwrite = ($urandom_range(0, 7) != 0);
            in_rd       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            in_wdsel    = 2'($urandom);
            in_aluout   = $urandom;
            in_imm      = $urandom;
            in_pc       = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : $urandom;
            in_funct3   = f3_tab[$urandom_range(0, 4)];
            in_addr_lo  = 2'($urandom);
            mem_rvalid  = ($urandom_range(0, 2) == 0);
            mem_rdata   = $urandom;
            flush       = ($urandom_range(0, 11) == 0);
            step();
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
